// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared ALU.
// Each request is latched into operand registers. The registers drive the ALU
// for one EXEC cycle, and the result is held in RESP until the consumer takes it.
// Optional feature macro ALU_ARB_LOCK_EN: a requester may keep the grant
// across several operations through req_lock_*.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  // requester 0
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic [4:0]  req_op_0,
  input  logic        req_size_0,
  input  logic [15:0] req_a_0,
  input  logic [15:0] req_b_0,
  input  logic        req_c_0,
  input  logic        req_lock_0,
  // requester 1
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic [4:0]  req_op_1,
  input  logic        req_size_1,
  input  logic [15:0] req_a_1,
  input  logic [15:0] req_b_1,
  input  logic        req_c_1,
  input  logic        req_lock_1,
  // response
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_r,
  output logic [3:0]  rsp_flags,
  // shared ALU
  output logic [4:0]  alu_op,
  output logic        alu_size,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_c,
  input  logic [15:0] alu_r,
  input  logic [3:0]  alu_flags,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_reg;
  logic        last_grant_reg;
  logic [4:0]  op_reg;
  logic        size_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic        c_reg;
  logic        id_reg;
  logic        rsp_valid_reg;
  logic        rsp_id_reg;
  logic [15:0] rsp_r_reg;
  logic [3:0]  rsp_flags_reg;

  logic        grant_0;
  logic        grant_1;
  logic        accept;
  logic        sel_lock;

`ifdef ALU_ARB_LOCK_EN
  logic        lock_active_reg;
  logic        lock_owner_reg;
`else
  // The lock inputs exist for interface compatibility only.
  logic        unused_lock;
  assign unused_lock = req_lock_0 | req_lock_1;
`endif

  // Arbitration: the only valid requester wins; on contention, the requester not served last wins.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    if (lock_active_reg) begin
      // While locked, only the owner may be granted, even if the owner is idle.
      grant_0 = req_valid_0 & ~lock_owner_reg;
      grant_1 = req_valid_1 &  lock_owner_reg;
    end else
`endif
    if (req_valid_0 && req_valid_1) begin
      grant_0 = last_grant_reg;
      grant_1 = ~last_grant_reg;
    end else begin
      grant_0 = req_valid_0;
      grant_1 = req_valid_1;
    end
  end

  // Ready is offered only in IDLE, so no request is accepted in the cycle that retires a result.
  assign req_ready_0 = (state_reg == IDLE) & grant_0;
  assign req_ready_1 = (state_reg == IDLE) & grant_1;
  assign accept      = req_ready_0 | req_ready_1;
  assign sel_lock    = grant_1 ? req_lock_1 : req_lock_0;

  // Control FSM, operand capture and result capture, all registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      op_reg         <= '0;
      size_reg       <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      c_reg          <= 1'b0;
      id_reg         <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_r_reg      <= '0;
      rsp_flags_reg  <= '0;
`ifdef ALU_ARB_LOCK_EN
      lock_active_reg <= 1'b0;
      lock_owner_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg         <= grant_1 ? req_op_1   : req_op_0;
            size_reg       <= grant_1 ? req_size_1 : req_size_0;
            a_reg          <= grant_1 ? req_a_1    : req_a_0;
            b_reg          <= grant_1 ? req_b_1    : req_b_0;
            c_reg          <= grant_1 ? req_c_1    : req_c_0;
            id_reg         <= grant_1;
            last_grant_reg <= grant_1;
`ifdef ALU_ARB_LOCK_EN
            // A locked request keeps ownership; the owner's unlocked request releases it.
            lock_active_reg <= sel_lock;
            lock_owner_reg  <= grant_1;
`endif
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          rsp_r_reg     <= alu_r;
          rsp_flags_reg <= alu_flags;
          rsp_id_reg    <= id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifndef ALU_ARB_LOCK_EN
  // The selected lock bit only matters when locking is built in.
  logic unused_sel_lock;
  assign unused_sel_lock = sel_lock;
`endif

  assign alu_op    = op_reg;
  assign alu_size  = size_reg;
  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_c     = c_reg;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_r     = rsp_r_reg;
  assign rsp_flags = rsp_flags_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  synchronous reset, active-low.
REQ-003 SHALL have ports, per requester i in {0,1}: req_valid_i input 1, request present; req_ready_i output 1, request accepted this cycle.
REQ-004 SHALL have ports, per requester i: req_op_i input 5, ALU opcode; req_size_i input 1, 0=8-bit 1=16-bit; req_a_i input 16, operand A; req_b_i input 16, operand B; req_c_i input 1, carry in; req_lock_i input 1, hold grant.
REQ-005 SHALL have ports: rsp_valid output 1, result held; rsp_ready input 1, consumer takes result; rsp_id output 1, requester index; rsp_r output 16, result; rsp_flags output 4, flags {S,V,C,Z} in bits [3:0] = S,V,C,Z with Z at bit 0.
REQ-006 SHALL have ports to the shared ALU: alu_op output 5, alu_size output 1, alu_a output 16, alu_b output 16, alu_c output 1; alu_r input 16, alu_flags input 4; busy output 1, state != IDLE.

Function
REQ-007 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; busy=1 in EXEC and RESP.
REQ-008 SHALL, in IDLE, assert req_ready_i combinationally only for the granted requester; req_ready is 0 in EXEC and RESP.
REQ-009 SHALL grant round-robin: single valid requester wins; both valid -> requester other than last_grant wins.
REQ-010 SHALL, on req_valid_i & req_ready_i, latch op/size/A/B/C and id into operand registers, update last_grant to i, and enter EXEC.
REQ-011 SHALL drive alu_* directly from the operand registers (stable from EXEC through RESP; hold last values in IDLE).
REQ-012 SHALL, in EXEC, capture alu_r and alu_flags into rsp_r/rsp_flags, set rsp_valid=1 next cycle, enter RESP.
REQ-013 SHALL give latency: accept in cycle N -> rsp_valid=1 in cycle N+2; peak throughput one op per 3 cycles.
REQ-014 SHALL hold rsp_valid, rsp_id, rsp_r, rsp_flags stable in RESP until rsp_ready=1; on that edge rsp_valid->0, enter IDLE.
REQ-015 SHALL forward any opcode unchanged, including undefined ones; ALU default output is returned as-is.
REQ-016 SHALL not accept a new request in the cycle rsp_ready retires a result (arbitration resumes in IDLE next cycle).

Reset
REQ-017 SHALL, while reset_n=0 at a clock edge: state=IDLE, rsp_valid=0, rsp_id=0, rsp_r=0, rsp_flags=0, operand registers=0, last_grant=1 (requester 0 favoured first), lock cleared.
REQ-018 SHALL discard any in-flight EXEC/RESP result on reset; no response is produced for it.

Configuration
REQ-019 SHALL support macro ALU_ARB_LOCK_EN.
REQ-020 SHALL, with ALU_ARB_LOCK_EN defined: an accepted request with req_lock_i=1 sets lock owner=i; while locked, only owner can be granted (other req_ready=0, even if owner idle); lock clears when owner's accepted request has req_lock_i=0.
REQ-021 SHALL, without ALU_ARB_LOCK_EN: req_lock_i ports present but ignored; pure round-robin.

Verification
REQ-022 SHALL cover: reset, req0 op=ADD size=0 A=0x007F B=0x0001 C=0 -> rsp_valid at N+2, rsp_id=0, rsp_r=0x0080, rsp_flags=4'b1100.
REQ-023 SHALL cover: req0 and req1 valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; each rsp_id matches.
REQ-024 SHALL cover: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both req_ready=0, no new accept; rsp_ready=1 -> IDLE next cycle.
REQ-025 SHALL cover: reset_n=0 during EXEC of req1 SUB A=0x0010 B=0x0001 -> no response emitted; next grant goes to requester 0.
REQ-026 SHALL cover (ALU_ARB_LOCK_EN): req1 issues ADD lock=1 then ADC lock=0 with req0 valid throughout -> both req1 ops served consecutively, then req0 granted.
